// File: rtl/fifo_rd_pack_pkg.sv
// fifo_rd_pack_pkg: state type and default widths shared by fifo_rd_packer.
package fifo_rd_pack_pkg;
  localparam int NIB_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {S_NONE, S_HALF, S_PAIR} state_t;
endpackage

// File: rtl/fifo_rd_pack_if.sv
// fifo_rd_pack_if: FIFO read port plus packed-word stream of fifo_rd_packer.
interface fifo_rd_pack_if import fifo_rd_pack_pkg::*; #(
  parameter int NIB_W = NIB_W_DEF
);
  logic empty_i;
  logic rd_en_o;
  logic [NIB_W-1:0] rd_data_i;
  logic flush_i;
  logic m_valid_o;
  logic m_ready_i;
  logic [2*NIB_W-1:0] m_data_o;
  modport master (
    input empty_i, rd_data_i, flush_i, m_ready_i,
    output rd_en_o, m_valid_o, m_data_o
  );
  modport slave (
    output empty_i, rd_data_i, flush_i, m_ready_i,
    input rd_en_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/fifo_rd_pack_oreg.sv
// fifo_rd_pack_oreg: valid/ready output register; data holds while stalled.
module fifo_rd_pack_oreg import fifo_rd_pack_pkg::*; #(
  parameter int W = 2*NIB_W_DEF
) (
  input  logic         r_clk_i,
  input  logic         r_rst_i,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);
  assign free = !valid || ready;
  always_ff @(posedge r_clk_i or posedge r_rst_i)
    if (r_rst_i) begin
      valid <= 1'b0;
      data <= '0;
    end else begin
      valid <= ld || (valid && !ready);
      if (ld) data <= d;
    end
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs pairs of FIFO nibbles into words {second, first}.
// Optional FIFO_RD_PACK_STAT_EN adds byte_cnt_o, a wrapping handshake count.
module fifo_rd_packer import fifo_rd_pack_pkg::*; #(
  parameter int NIB_W = NIB_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic r_clk_i,
  input logic r_rst_i,
  fifo_rd_pack_if.master bus
`ifdef FIFO_RD_PACK_STAT_EN
  , output logic [CNT_W-1:0] byte_cnt_o
`endif
);
  state_t st, st_nx;
  logic inflight, cap, ld, free;
  logic [1:0] used;
  logic [2*NIB_W-1:0] pair;
  assign ld = st == S_PAIR && free;
  assign cap = inflight && !bus.flush_i;
  // a pair moving to the output register frees both slots on that edge, keeping 1 word / 3 cycles
  assign used = (st == S_PAIR && !ld) ? 2'd2 : st == S_HALF ? 2'd1 : 2'd0;
  assign bus.rd_en_o = !r_rst_i && !bus.empty_i && !bus.flush_i && (used + {1'b0, inflight} < 2'd2);
  always_comb begin
    st_nx = st;
    if (bus.flush_i || ld) st_nx = S_NONE;
    else if (cap) st_nx = st == S_NONE ? S_HALF : S_PAIR;
  end
  always_ff @(posedge r_clk_i or posedge r_rst_i)
    if (r_rst_i) begin
      st <= S_NONE;
      inflight <= 1'b0;
      pair <= '0;
    end else begin
      st <= st_nx;
      inflight <= bus.rd_en_o;
      if (cap && st == S_NONE) pair[NIB_W-1:0] <= bus.rd_data_i;
      if (cap && st == S_HALF) pair[2*NIB_W-1:NIB_W] <= bus.rd_data_i;
    end
  fifo_rd_pack_oreg #(.W(2*NIB_W)) u_oreg (
    .r_clk_i(r_clk_i),
    .r_rst_i(r_rst_i),
    .ld(ld),
    .d(pair),
    .ready(bus.m_ready_i),
    .valid(bus.m_valid_o),
    .data(bus.m_data_o),
    .free(free)
  );
`ifdef FIFO_RD_PACK_STAT_EN
  always_ff @(posedge r_clk_i or posedge r_rst_i)
    if (r_rst_i) byte_cnt_o <= '0;
    else if (bus.m_valid_o && bus.m_ready_i) byte_cnt_o <= byte_cnt_o + 1'b1;
`endif
endmodule
